ex_9_dispatch: RTL and testbench
================================

# ex_9_dispatch

Registered one-to-six data dispatcher: the distribution end of the six-way priority select path. A 4-bit word arrives on a valid/ready input, and the same sel1..sel5 priority chain used on the selection side decodes it into one of six destination slots a..f. Each slot is a one-entry holding register with its own valid/ack handshake toward its sink. The block sits between a single producer and six independent 4-bit consumers.

## Interface
- WIDTH, 4, data width of input word and each slot
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  dispatcher can accept the word for the decoded destination
- in_data  input  WIDTH  word to dispatch
- sel1, sel2, sel3, sel4, sel5  input  1 each  destination select, priority-decoded (see Operation)
- a, b, c, d, e, f  output  WIDTH each  slot data registers
- out_valid  output  6  per-slot full flag; bit0=a … bit5=f
- out_ack  input  6  per-slot consume strobe from sinks
- occupancy  output  3  number of full slots, 0..6
- last_dest  output  3  index (0=a … 5=f) of the most recently accepted word

## Operation
- Destination decode is combinational, with priority as follows:
  - sel1 gives a (0).
  - Otherwise, sel2&sel3 gives b (1).
  - Otherwise, sel2&!sel3 gives c (2).
  - Otherwise, !sel2&sel4 gives d (3).
  - Otherwise, sel5 gives e (4).
  - Otherwise, the destination is f (5).
- Lower-priority selects are don't-care once a higher one wins.
- Each slot is a two-state machine:
  - EMPTY: out_valid[i]=0.
  - FULL: out_valid[i]=1, slot data stable.
  - EMPTY goes to FULL on accept to slot i.
  - FULL goes to EMPTY on out_ack[i] with no accept to slot i in the same cycle.
  - FULL stays FULL on accept to slot i. This requires out_ack[i] in the same cycle, and the data is replaced.
- in_ready = !out_valid[dest] | out_ack[dest]. It is combinational from the sel inputs, out_valid and out_ack. It does not depend on in_valid.
- Accept = in_valid & in_ready. On accept:
  - slot[dest] ← in_data
  - out_valid[dest] ← 1
  - last_dest ← dest
- out_ack[i] while out_valid[i]=0 is ignored. It causes no state change and no error.
- Acks to slots other than dest act independently in the same cycle. Any number of slots may drain at once.
- Slot data registers hold their value after draining. Only an accept writes them.
- occupancy is a registered counter updated each cycle by (+1 if accept into an EMPTY slot) − (number of FULL slots acked and not re-written). Accept-with-ack on the same slot gives net 0. The counter never exceeds 6 or drops below 0. The verifier checks occupancy == popcount(out_valid) every cycle.

## Timing
- Reset (rst_n low, asynchronous, immediate):
  - a..f = 0
  - out_valid = 0
  - occupancy = 0
  - last_dest = 0
- in_ready is combinational. With all slots empty, in_ready = 1 during and after reset.
- Reset asserted mid-operation discards all held words at once. No handshake completes in that cycle.
- Latency: a word accepted at edge N is visible on its slot output with out_valid=1 after edge N.
- A slot drains at the edge where out_ack is sampled high. out_valid falls after that edge.
- Throughput:
  - One word per cycle when successive destinations differ or the sink acks each cycle.
  - Back-to-back writes to the same slot with ack sustained high pass one word per cycle.
  - Without ack, the second word to a full slot stalls (in_ready=0) until the sink acks.
- A stall on one destination does not block acks on other slots. in_ready reflects only the currently decoded destination.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-traffic with three slots full.
  - Required: out_valid=0, occupancy=0 and a..f=0 immediately, without waiting for a clock. in_ready=1.
- Priority decode sweep:
  - Stimulus: with all slots empty, send 4'h1..4'h6 using sel patterns {1xxxx}, {01 1xx}, {010xx}, {00x1x}, {00x01}, {00x00}.
  - Required: a=1, b=2, c=3, d=4, e=5, f=6; out_valid=6'b111111; occupancy=6; last_dest=5.
- Backpressure:
  - Stimulus: with slot d full holding 4'h9 and no ack, present 4'hA to d.
  - Required: in_ready=0 and d stays 9 for 5 cycles.
  - Stimulus: then pulse out_ack[3].
  - Required: 4'hA is accepted in that same cycle; d=A after the edge; out_valid[3] stays 1; occupancy unchanged.
- Independent drain:
  - Stimulus: with slots a, c and f full, assert out_ack=6'b100101 for one cycle while writing 4'h7 to b.
  - Required: out_valid=6'b000010, occupancy=1, b=7, last_dest=1.
- Spurious ack:
  - Stimulus: with all slots empty, assert out_ack=6'b111111.
  - Required: no change; occupancy stays 0.
- Streaming:
  - Stimulus: run 32 random words to slot e with out_ack[4] held high and in_valid continuous.
  - Required: one accept per cycle; e follows in_data with one-cycle lag; occupancy is 1 throughout after the first accept.

Source files
------------

// File: rtl/ex_9_dispatch.sv
// One-to-six dispatcher: priority-decoded sel1..sel5 routes each accepted word into one of six one-entry slots (a..f).
// Word is visible on its slot one edge after accept; in_ready drops only while the decoded slot is full and not being acked.
module ex_9_dispatch #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sel1,
   input  logic             sel2,
   input  logic             sel3,
   input  logic             sel4,
   input  logic             sel5,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [5:0]       out_valid,
   input  logic [5:0]       out_ack,
   output logic [2:0]       occupancy,
   output logic [2:0]       last_dest
);

   logic [2:0]            dest;
   logic                  accept;
   logic [5:0]            acc_mask;
   logic [5:0]            vld_q, vld_d;
   logic [5:0][WIDTH-1:0] slot_q, slot_d;
   logic [2:0]            occ_q, occ_d;
   logic [2:0]            last_q, last_d;
   logic [2:0]            drained;

   // Earlier terms win; later selects are don't-care once a higher one matches.
   always_comb begin
      dest = 3'd5;
      if (sel1)              dest = 3'd0;
      else if (sel2 && sel3) dest = 3'd1;
      else if (sel2)         dest = 3'd2;
      else if (sel4)         dest = 3'd3;
      else if (sel5)         dest = 3'd4;
   end

   assign in_ready = !vld_q[dest] || out_ack[dest];
   assign accept   = in_valid && in_ready;

   always_comb begin
      acc_mask = '0;
      slot_d   = slot_q;
      last_d   = last_q;
      drained  = '0;
      if (accept) begin
         acc_mask[dest] = 1'b1;
         slot_d[dest]   = in_data;
         last_d         = dest;
      end
      // Acks on empty slots fall out naturally: they clear nothing and count nothing.
      vld_d = (vld_q & ~out_ack) | acc_mask;
      for (int i = 0; i < 6; i++) begin
         drained = drained + {2'b00, vld_q[i] & out_ack[i] & ~acc_mask[i]};
      end
      occ_d = occ_q + {2'b00, accept & ~vld_q[dest]} - drained;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         slot_q <= '0;
         occ_q  <= '0;
         last_q <= '0;
      end else begin
         vld_q  <= vld_d;
         slot_q <= slot_d;
         occ_q  <= occ_d;
         last_q <= last_d;
      end
   end

   assign a         = slot_q[0];
   assign b         = slot_q[1];
   assign c         = slot_q[2];
   assign d         = slot_q[3];
   assign e         = slot_q[4];
   assign f         = slot_q[5];
   assign out_valid = vld_q;
   assign occupancy = occ_q;
   assign last_dest = last_q;

endmodule

// File: tb/tb_ex_9_dispatch.sv
// Directed bench for ex_9_dispatch: per-scenario tasks with inline hand-computed checks.
module tb_ex_9_dispatch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       sel1, sel2, sel3, sel4, sel5;
   logic [3:0] a, b, c, d, e, f;
   logic [5:0] out_valid;
   logic [5:0] out_ack;
   logic [2:0] occupancy;
   logic [2:0] last_dest;

   int checks = 0;
   int errors = 0;

   ex_9_dispatch #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .sel5(sel5),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
      .out_valid(out_valid), .out_ack(out_ack), .occupancy(occupancy), .last_dest(last_dest)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Select patterns with don't-care bits set to 1 wherever allowed, to exercise priority.
   task automatic set_dest(input int idx);
      case (idx)
         0:       {sel1, sel2, sel3, sel4, sel5} = 5'b11111;
         1:       {sel1, sel2, sel3, sel4, sel5} = 5'b01111;
         2:       {sel1, sel2, sel3, sel4, sel5} = 5'b01011;
         3:       {sel1, sel2, sel3, sel4, sel5} = 5'b00111;
         4:       {sel1, sel2, sel3, sel4, sel5} = 5'b00101;
         default: {sel1, sel2, sel3, sel4, sel5} = 5'b00100;
      endcase
   endtask

   task automatic write_word(input int idx, input logic [3:0] val);
      set_dest(idx);
      in_data  = val;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      out_ack = 6'b111111;
      tick();
      out_ack = 6'b000000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ack = 6'b0;
      {sel1, sel2, sel3, sel4, sel5} = 5'b00000;
      #1;
      checks++; if (out_valid !== 6'b0) begin errors++; $display("FAIL reset_valid got %b want 000000", out_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
      checks++; if ({a, b, c, d, e, f} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", {a, b, c, d, e, f}); end
      checks++; if (last_dest !== 3'd0) begin errors++; $display("FAIL reset_last got %0d want 0", last_dest); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_priority_sweep();
      for (int i = 0; i < 6; i++) begin
         set_dest(i);
         in_data  = 4'(i + 1);
         in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready[%0d] got %b want 1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      checks++; if ({a, b, c, d, e, f} !== 24'h123456) begin errors++; $display("FAIL sweep_data got %h want 123456", {a, b, c, d, e, f}); end
      checks++; if (out_valid !== 6'b111111) begin errors++; $display("FAIL sweep_valid got %b want 111111", out_valid); end
      checks++; if (occupancy !== 3'd6) begin errors++; $display("FAIL sweep_occ got %0d want 6", occupancy); end
      checks++; if (last_dest !== 3'd5) begin errors++; $display("FAIL sweep_last got %0d want 5", last_dest); end
      drain_all();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_all_occ got %0d want 0", occupancy); end
      checks++; if (out_valid !== 6'b0) begin errors++; $display("FAIL drain_all_valid got %b want 000000", out_valid); end
   endtask

   task automatic test_backpressure();
      write_word(3, 4'h9);
      set_dest(3);
      in_data  = 4'hA;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
         checks++; if (d !== 4'h9) begin errors++; $display("FAIL bp_hold[%0d] got %h want 9", i, d); end
         tick();
      end
      out_ack = 6'b001000;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ack_ready got %b want 1", in_ready); end
      tick();
      out_ack  = 6'b0;
      in_valid = 1'b0;
      checks++; if (d !== 4'hA) begin errors++; $display("FAIL bp_replace got %h want a", d); end
      checks++; if (out_valid !== 6'b001000) begin errors++; $display("FAIL bp_valid got %b want 001000", out_valid); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL bp_occ got %0d want 1", occupancy); end
      drain_all();
   endtask

   task automatic test_independent_drain();
      write_word(0, 4'h1);
      write_word(2, 4'h2);
      write_word(5, 4'h3);
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL drain_pre_occ got %0d want 3", occupancy); end
      out_ack = 6'b100101;
      write_word(1, 4'h7);
      out_ack = 6'b0;
      checks++; if (out_valid !== 6'b000010) begin errors++; $display("FAIL drain_valid got %b want 000010", out_valid); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL drain_occ got %0d want 1", occupancy); end
      checks++; if (b !== 4'h7) begin errors++; $display("FAIL drain_b got %h want 7", b); end
      checks++; if (last_dest !== 3'd1) begin errors++; $display("FAIL drain_last got %0d want 1", last_dest); end
      checks++; if (a !== 4'h1) begin errors++; $display("FAIL drain_hold_a got %h want 1", a); end
      drain_all();
   endtask

   task automatic test_spurious_ack();
      out_ack = 6'b111111;
      tick();
      tick();
      out_ack = 6'b0;
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL spur_occ got %0d want 0", occupancy); end
      checks++; if (out_valid !== 6'b0) begin errors++; $display("FAIL spur_valid got %b want 000000", out_valid); end
      checks++; if (b !== 4'h7) begin errors++; $display("FAIL spur_b got %h want 7", b); end
      checks++; if (last_dest !== 3'd1) begin errors++; $display("FAIL spur_last got %0d want 1", last_dest); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sent;
      set_dest(4);
      out_ack  = 6'b010000;
      in_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         sent    = 4'($urandom_range(15));
         in_data = sent;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
         tick();
         checks++; if (e !== sent) begin errors++; $display("FAIL stream_e[%0d] got %h want %h", i, e, sent); end
         checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
         checks++; if (out_valid !== 6'b010000) begin errors++; $display("FAIL stream_valid[%0d] got %b want 010000", i, out_valid); end
      end
      in_valid = 1'b0;
      tick();
      out_ack = 6'b0;
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_end_occ got %0d want 0", occupancy); end
      checks++; if (last_dest !== 3'd4) begin errors++; $display("FAIL stream_last got %0d want 4", last_dest); end
   endtask

   task automatic test_reset_mid();
      write_word(0, 4'hC);
      write_word(1, 4'hD);
      write_word(2, 4'hE);
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL midrst_pre_occ got %0d want 3", occupancy); end
      set_dest(0);
      in_data  = 4'hF;
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 6'b0) begin errors++; $display("FAIL midrst_valid got %b want 000000", out_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL midrst_occ got %0d want 0", occupancy); end
      checks++; if ({a, b, c, d, e, f} !== 24'h0) begin errors++; $display("FAIL midrst_data got %h want 000000", {a, b, c, d, e, f}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 6'b0) begin errors++; $display("FAIL midrst_hold_valid got %b want 000000", out_valid); end
      checks++; if (a !== 4'h0) begin errors++; $display("FAIL midrst_hold_a got %h want 0", a); end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_priority_sweep();
      test_backpressure();
      test_independent_drain();
      test_spurious_ack();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
